// File: rtl/v_noc_pkg.sv
// Shared NoC types plus the scoreboard-check arbiter defaults.
package v_noc_pkg;

  localparam bit ENABLE_TXN_ID = 1'b1;

  localparam int REC_ID_W = 3;
  localparam int SRC_ID_W = 4;
  localparam int TXN_ID_W = ENABLE_TXN_ID ? 8 : 1;
  localparam int FLIT_W   = 32;

  // Payload a receiver hands to the scoreboard for checking.
  typedef struct packed {
    logic [REC_ID_W-1:0] rec_id;
    logic [SRC_ID_W-1:0] src_id;
    logic [TXN_ID_W-1:0] txn_id;
    logic [FLIT_W-1:0]   flit_data;
  } receiver_info_t;

  localparam int SB_ARB_REQ_NUM    = 5;
  localparam int SB_ARB_FIFO_DEPTH = 4;

  typedef enum logic {
    SB_IDLE,
    SB_LOCKED
  } sb_arb_state_e;

endpackage

// File: rtl/v_sb_arb_fifo.sv
// Per-requester sync FIFO. A push into a full FIFO lands only when the same
// cycle pops; otherwise it is silently discarded (the arbiter counts it).
module v_sb_arb_fifo
  import v_noc_pkg::*;
#(
  parameter int DEPTH = SB_ARB_FIFO_DEPTH
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  receiver_info_t din,
  output logic           full,
  output logic           empty,
  output logic           nonempty_next,
  output receiver_info_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    cnt, cnt_next;
  logic           do_push, do_pop;
  receiver_info_t mem [DEPTH];

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Occupancy after this edge; lets the arbiter lock onto data pushed now.
  assign cnt_next      = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign nonempty_next = (cnt_next != '0);
  assign head          = mem[rd_ptr];

  // Pointer/occupancy state; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_next;
    end
  end

  // Storage; when full with a pop, wr_ptr == rd_ptr so the new entry
  // reuses the slot being freed.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/v_scoreboard_check_arb.sv
// Merges REQ_NUM receiver check streams onto one scoreboard port.
// Each receiver gets a small FIFO; a round-robin pick locks the port until
// the scoreboard accepts, so the presented grant/payload never changes
// while valid is up.
module v_scoreboard_check_arb
  import v_noc_pkg::*;
#(
  parameter  int REQ_NUM    = SB_ARB_REQ_NUM,
  parameter  int FIFO_DEPTH = SB_ARB_FIFO_DEPTH,
  localparam int GW         = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic           [REQ_NUM-1:0]  req_vld_i,
  input  receiver_info_t [REQ_NUM-1:0]  req_i,
  output logic                          check_scoreboard_vld_o,
  output receiver_info_t                check_scoreboard_o,
  input  logic                          check_scoreboard_rdy_i,
  output logic           [GW-1:0]       grant_id_o,
  output logic           [REQ_NUM-1:0]  overflow_o,
  output logic           [15:0]         drop_cnt_o
);

  localparam int DW = $clog2(REQ_NUM + 1);

  sb_arb_state_e                state, state_next;
  logic           [GW-1:0]      grant_next, rr_ptr, rr_next;
  logic           [REQ_NUM-1:0] full, empty, nonempty_next, pop, drop;
  receiver_info_t [REQ_NUM-1:0] head;
  logic                         hs;
  logic           [DW-1:0]      drop_n;
  logic           [16:0]        drop_sum;
  logic           [15:0]        drop_cnt_next;

  assign check_scoreboard_vld_o = (state == SB_LOCKED);
  assign check_scoreboard_o     = head[grant_id_o];
  assign hs                     = check_scoreboard_vld_o & check_scoreboard_rdy_i;

  // A push is lost when its FIFO is full and is not being drained this cycle.
  assign drop = req_vld_i & full & ~pop;

  for (genvar p = 0; p < REQ_NUM; p++) begin : g_fifo
    assign pop[p] = hs & (grant_id_o == GW'(p)) & ~empty[p];

    v_sb_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk           (clk),
      .rst           (rst),
      .push          (req_vld_i[p]),
      .pop           (pop[p]),
      .din           (req_i[p]),
      .full          (full[p]),
      .empty         (empty[p]),
      .nonempty_next (nonempty_next[p]),
      .head          (head[p])
    );
  end

  // First set bit of m at or after ptr, wrapping past REQ_NUM-1.
  function automatic logic [GW-1:0] rr_pick(input logic [REQ_NUM-1:0] m,
                                            input logic [GW-1:0]      ptr);
    logic found;
    int   idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      idx = (int'(ptr) + i) % REQ_NUM;
      if (!found && m[idx]) begin
        rr_pick = GW'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  // Lock FSM: pick from next-cycle FIFO contents so a push at edge t is
  // presented at t+1 and back-to-back transfers need no idle bubble.
  always_comb begin
    state_next = state;
    grant_next = grant_id_o;
    rr_next    = rr_ptr;
    case (state)
      SB_IDLE: begin
        if (|nonempty_next) begin
          state_next = SB_LOCKED;
          grant_next = rr_pick(nonempty_next, rr_ptr);
        end
      end
      SB_LOCKED: begin
        if (hs) begin
          rr_next = (grant_id_o == GW'(REQ_NUM - 1)) ? '0 : grant_id_o + 1'b1;
          if (|nonempty_next) grant_next = rr_pick(nonempty_next, rr_next);
          else                state_next = SB_IDLE;
        end
      end
      default: state_next = SB_IDLE;
    endcase
  end

  // Several ports may drop at once; add them all and clamp at 16'hFFFF.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < REQ_NUM; i++) drop_n = drop_n + DW'(drop[i]);
    drop_sum      = {1'b0, drop_cnt_o} + 17'(drop_n);
    drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Arbiter state and sticky error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SB_IDLE;
      grant_id_o <= '0;
      rr_ptr     <= '0;
      overflow_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      state      <= state_next;
      grant_id_o <= grant_next;
      rr_ptr     <= rr_next;
      overflow_o <= overflow_o | drop;
      drop_cnt_o <= drop_cnt_next;
    end
  end

endmodule

// File: tb/tb_v_scoreboard_check_arb.sv
// Scoreboard bench: per-port expected queues filled when requests are
// driven, drained and compared when the DUT hands an entry over.
module tb_v_scoreboard_check_arb;
  import v_noc_pkg::*;

  localparam int N = 5;
  localparam int D = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic           [N-1:0] req_vld;
  receiver_info_t [N-1:0] req;
  logic                   vld, rdy;
  receiver_info_t         payload;
  logic           [2:0]   grant;
  logic           [N-1:0] ovf;
  logic           [15:0]  drop_cnt;

  v_scoreboard_check_arb #(.REQ_NUM(N), .FIFO_DEPTH(D)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_vld_i              (req_vld),
    .req_i                  (req),
    .check_scoreboard_vld_o (vld),
    .check_scoreboard_o     (payload),
    .check_scoreboard_rdy_i (rdy),
    .grant_id_o             (grant),
    .overflow_o             (ovf),
    .drop_cnt_o             (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model
  receiver_info_t mq [N][$];
  int             m_rr, m_grant, m_drop, seq;
  bit             m_vld;
  logic   [N-1:0] m_ovf;

  function automatic int pick();
    for (int i = 0; i < N; i++)
      if (mq[(m_rr + i) % N].size() != 0) return (m_rr + i) % N;
    return 0;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < N; p++) mq[p].delete();
    m_rr = 0; m_grant = 0; m_vld = 0; m_drop = 0; m_ovf = '0;
  endtask

  task automatic drive(input logic [N-1:0] mask);
    req_vld = mask;
    for (int p = 0; p < N; p++) begin
      seq++;
      req[p].rec_id    = REC_ID_W'(p);
      req[p].src_id    = SRC_ID_W'(seq);
      req[p].txn_id    = TXN_ID_W'(seq);
      req[p].flit_data = $urandom;
    end
  endtask

  // Compare present outputs, advance the model over one edge, clock it.
  task automatic step();
    bit hs;
    receiver_info_t e;
    chk("vld", 64'(vld), 64'(m_vld));
    if (m_vld) begin
      chk("grant", 64'(grant), 64'(m_grant));
      chk("payload", 64'(payload), 64'(mq[m_grant][0]));
    end
    chk("overflow", 64'(ovf), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    hs = m_vld && rdy && !rst;
    if (rst) model_clear();
    else begin
      if (hs) e = mq[m_grant].pop_front();
      for (int p = 0; p < N; p++)
        if (req_vld[p]) begin
          if (mq[p].size() < D) mq[p].push_back(req[p]);
          else begin
            m_ovf[p] = 1'b1;
            if (m_drop < 65535) m_drop++;
          end
        end
      if (hs) m_rr = (m_grant + 1) % N;
      if (!m_vld || hs) begin
        m_vld   = 1'b0;
        m_grant = pick();
        for (int p = 0; p < N; p++) if (mq[p].size() != 0) m_vld = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    req_vld = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_vld = '0;
    step();
    chk("rst_vld", 64'(vld), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] all_ports;
    all_ports = '1;
    seq = 0;
    rst = 1'b1; rdy = 1'b0; req_vld = '0; req = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Single request from port 2
    rdy = 1'b1;
    drive(5'b00100);
    req[2].src_id = 4'd3;
    step();
    chk("single_vld", 64'(vld), 64'd1);
    chk("single_grant", 64'(grant), 64'd2);
    chk("single_src", 64'(payload.src_id), 64'd3);
    step();
    chk("single_done", 64'(vld), 64'd0);

    // Fairness from rr_ptr=0, then from rr_ptr=2
    do_reset();
    rdy = 1'b1;
    drive(all_ports);
    step();
    for (int i = 0; i < N; i++) begin
      chk("rr0_grant", 64'(grant), 64'(i));
      step();
    end
    drive(5'b00010);
    step();
    step();
    drive(all_ports);
    step();
    for (int i = 0; i < N; i++) begin
      chk("rr2_grant", 64'(grant), 64'((i + 2) % N));
      step();
    end

    // Backpressure holds grant and payload
    do_reset();
    rdy = 1'b0;
    drive(5'b00010);
    step();
    for (int i = 0; i < 10; i++) begin
      logic [63:0] held;
      held = 64'(payload);
      chk("bp_grant", 64'(grant), 64'd1);
      drive(i < 3 ? 5'b00001 : 5'b00000);
      step();
      chk("bp_payload", 64'(payload), held);
    end
    rdy = 1'b1;
    step();
    chk("bp_next", 64'(grant), 64'd0);
    step(); step(); step(); step();

    // Overflow on port 4, then full + pop + push
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(5'b10000);
      step();
    end
    chk("ovf_flag", 64'(ovf), 64'h10);
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    rdy = 1'b1;
    drive(5'b10000);
    step();
    chk("fullpp_drop", 64'(drop_cnt), 64'd2);
    rdy = 1'b0;
    step();

    // Reset in mid-operation discards everything
    do_reset();
    rdy = 1'b0;
    drive(5'b01011);
    step();
    chk("mid_vld_pre", 64'(vld), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_vld", 64'(vld), 64'd0);
    chk("mid_grant", 64'(grant), 64'd0);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] m;
      for (int p = 0; p < N; p++) m[p] = ($urandom_range(0, 2) == 0);
      rdy = 1'($urandom_range(0, 1));
      drive(m);
      step();
    end

    // Saturating drop counter
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 13200; i++) begin
      drive(all_ports);
      step();
    end
    chk("sat_drop", 64'(drop_cnt), 64'hFFFF);
    chk("sat_ovf", 64'(ovf), 64'h1F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/v_scoreboard_check_arb.md
V_SCOREBOARD_CHECK_ARB -- requirements
Module: v_scoreboard_check_arb

Interface
REQ-001 Parameter REQ_NUM, default 5, number of receivers (N,S,E,W,L) sharing the scoreboard check port.
REQ-002 Parameter FIFO_DEPTH, default 4, per-requester buffer entries; power of two, >=2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_vld_i  input  REQ_NUM  per-receiver check request valid; no ready is returned.
REQ-006 req_i  input  REQ_NUM x receiver_info_t  per-receiver check payload (rec_id, src_id, txn_id if ENABLE_TXN_ID, flit_data).
REQ-007 check_scoreboard_vld_o  output  1  merged request valid to scoreboard.
REQ-008 check_scoreboard_o  output  receiver_info_t  merged payload.
REQ-009 check_scoreboard_rdy_i  input  1  scoreboard accept.
REQ-010 grant_id_o  output  $clog2(REQ_NUM)  requester index currently presented.
REQ-011 overflow_o  output  REQ_NUM  sticky per-requester drop flag.
REQ-012 drop_cnt_o  output  16  total dropped requests, saturating.

Function
REQ-013 Each requester SHALL own a FIFO_DEPTH sync FIFO; req_vld_i[p] pushes req_i[p] at the clock edge.
REQ-014 Push into a full FIFO SHALL succeed only if that FIFO pops in the same cycle; otherwise the entry is dropped, overflow_o[p] set, drop_cnt_o incremented (saturate at 16'hFFFF).
REQ-015 Multiple drops in one cycle SHALL add their count to drop_cnt_o, saturating.
REQ-016 No bypass: a request pushed at edge t SHALL be presentable no earlier than cycle t+1.
REQ-017 States: IDLE (no lock) and LOCKED (port held); IDLE->LOCKED when any FIFO is non-empty; LOCKED->IDLE on handshake when no FIFO will be non-empty next cycle, else LOCKED stays with newly selected port.
REQ-018 Selection SHALL be round-robin: first non-empty FIFO at or after rr_ptr, wrapping REQ_NUM-1 -> 0.
REQ-019 Once check_scoreboard_vld_o is asserted, grant_id_o and check_scoreboard_o SHALL remain stable until vld&rdy (no withdrawal, no re-arbitration).
REQ-020 On handshake with port p: pop FIFO p, rr_ptr <= (p+1) mod REQ_NUM; a new selection may be presented the next cycle (one transfer per cycle sustained).
REQ-021 check_scoreboard_vld_o SHALL be 1 exactly when LOCKED; payload and grant_id_o are don't-care while 0.
REQ-022 rdy asserted while vld is 0 SHALL have no effect.
REQ-023 Simultaneous push and pop on one FIFO SHALL keep occupancy unchanged, including when full or holding one entry.
REQ-024 Pointer and occupancy arithmetic SHALL wrap modulo FIFO_DEPTH; occupancy width $clog2(FIFO_DEPTH)+1.

Reset
REQ-025 While rst=1: all FIFOs empty, rr_ptr=0, state IDLE, check_scoreboard_vld_o=0, grant_id_o=0, overflow_o=0, drop_cnt_o=0; inputs ignored.
REQ-026 Reset asserted mid-transfer SHALL discard the presented and all buffered entries without handshake; first valid request possible one cycle after rst deasserts.
REQ-027 overflow_o and drop_cnt_o SHALL clear only on reset.

Structure
REQ-028 receiver_info_t stays in v_noc_pkg; SB_ARB_REQ_NUM=5 and SB_ARB_FIFO_DEPTH=4 defaults SHALL be added there.
REQ-029 Per-requester buffering SHALL be one sub-module v_sb_arb_fifo (sync FIFO, push/pop/full/empty/head), instantiated REQ_NUM times.
REQ-030 Arbiter, lock FSM and counters SHALL live in v_scoreboard_check_arb; no latches, no combinational path from req_vld_i to check_scoreboard_vld_o.

Verification
REQ-031 Single request: port 2 pushes src_id=3 at cycle 0, rdy=1 -> vld=1, grant_id_o=2 at cycle 1, vld=0 at cycle 2.
REQ-032 Fairness: all 5 ports push one entry at cycle 0, rdy=1 -> grants 0,1,2,3,4 on cycles 1-5; repeat from rr_ptr=2 gives 2,3,4,0,1.
REQ-033 Backpressure: port 1 pending, rdy=0 for 10 cycles while port 0 pushes -> grant_id_o and payload stable at 1 for all 10 cycles, port 0 served after.
REQ-034 Overflow: rdy=0, port 4 pushes 6 entries -> 4 buffered, overflow_o=5'b10000, drop_cnt_o=2; full+pop+push same cycle -> no drop.
REQ-035 Mid-operation reset: 3 ports loaded, vld=1, rst pulsed 1 cycle -> vld=0, all outputs at reset values, no stale entry presented after.
REQ-036 Saturation: force 65537 drops -> drop_cnt_o holds 16'hFFFF.
